// File: rtl/gelato_fetch_arbiter.sv
// Warp fetch arbiter: picks one eligible warp per cycle and registers its PC/split as an I-fetch request.
// Latency: issue_valid pulses in the selection cycle; fetch_valid rises the following cycle.
// Backpressure: while fetch_valid & !fetch_ready the request is frozen and no warp is selected.
module gelato_fetch_arbiter #(
    parameter int WARP_NUM        = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int SPLIT_WIDTH     = 4,
    parameter int MAX_OUTSTANDING = 1,
    parameter int GREEDY          = 0,
    localparam int WID_W          = $clog2(WARP_NUM),
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WARP_NUM-1:0]             pct_valid,
    input  logic [WARP_NUM*ADDR_WIDTH-1:0]  pct_pc,
    input  logic [WARP_NUM*SPLIT_WIDTH-1:0] pct_split,
    input  logic [WARP_NUM-1:0]             warp_stall,
    output logic                            issue_valid,
    output logic [WID_W-1:0]                issue_warp,
    output logic                            fetch_valid,
    input  logic                            fetch_ready,
    output logic [ADDR_WIDTH-1:0]           fetch_pc,
    output logic [WID_W-1:0]                fetch_warp,
    output logic [SPLIT_WIDTH-1:0]          fetch_split,
    input  logic                            resp_valid,
    input  logic [WID_W-1:0]                resp_warp,
    output logic                            err_underflow
);

    logic [CNT_W-1:0]    cnt [WARP_NUM];
    logic [WID_W-1:0]    ptr;
    logic [WARP_NUM-1:0] eligible;
    logic [WARP_NUM-1:0] inc_vec;
    logic [WARP_NUM-1:0] dec_vec;
    logic                load;
    logic                found;
    logic [WID_W-1:0]    sel;

    // The request register may only be refilled when empty or draining this cycle.
    assign load        = ~fetch_valid | fetch_ready;
    assign issue_valid = load & found & ~rst;
    assign issue_warp  = sel;

    // A warp is a candidate when it has a PC, is not back-pressured and still holds a credit.
    always_comb begin
        for (int w = 0; w < WARP_NUM; w++) begin
            eligible[w] = pct_valid[w] & ~warp_stall[w] & (cnt[w] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // Greedy keeps the last winner if it is still eligible; otherwise scan from ptr+1 with ptr itself last.
    always_comb begin
        logic [WID_W-1:0] cand;
        found = 1'b0;
        sel   = ptr;
        cand  = ptr;
        if (GREEDY != 0 && eligible[ptr]) begin
            found = 1'b1;
        end
        for (int k = 1; k <= WARP_NUM; k++) begin
            cand = WID_W'((int'(ptr) + k) % WARP_NUM);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Per-warp credit take (issue) and return (response) strobes.
    always_comb begin
        for (int w = 0; w < WARP_NUM; w++) begin
            inc_vec[w] = issue_valid & (sel == WID_W'(w));
            dec_vec[w] = resp_valid & (resp_warp == WID_W'(w));
        end
    end

    // Request register: snapshot the winner's PC/split; clear valid when a load finds no winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_warp  <= '0;
            fetch_split <= '0;
            ptr         <= WID_W'(WARP_NUM - 1);
        end else if (issue_valid) begin
            fetch_valid <= 1'b1;
            fetch_pc    <= pct_pc[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            fetch_warp  <= sel;
            fetch_split <= pct_split[int'(sel)*SPLIT_WIDTH +: SPLIT_WIDTH];
            ptr         <= sel;
        end else if (load) begin
            fetch_valid <= 1'b0;
        end
    end

    // Credit counters; a same-cycle take and return cancel, a return with no credit out is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WARP_NUM; w++) begin
                cnt[w] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int w = 0; w < WARP_NUM; w++) begin
                if (inc_vec[w] && !dec_vec[w]) begin
                    cnt[w] <= cnt[w] + 1'b1;
                end else if (dec_vec[w] && !inc_vec[w]) begin
                    if (cnt[w] == '0) begin
                        err_underflow <= 1'b1;
                    end else begin
                        cnt[w] <= cnt[w] - 1'b1;
                    end
                end
            end
        end
    end

endmodule
